riscv_multicycle_control: RTL and testbench

Main control FSM for the multicycle RISC-V core. It sequences instruction fetch, decode, execute, memory access and writeback over several cycles through one shared ALU. It drives the same 2-bit ALUOp code the ALU control decoder already consumes: 00 add, 01 subtract, 10 R-type by funct7/funct3, 11 I-type by funct7/funct3. It stalls on a single-port memory ready handshake.

---
 rtl/riscv_multicycle_control.sv | 178 +++++++++++++++++
 tb/tb_riscv_multicycle_control.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_control.sv
// Main control FSM for the multicycle RISC-V core.
// Optional: define RISCV_MC_ILLEGAL_TRAP_EN to halt on illegal opcodes.
module riscv_multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               adr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [STATE_W-1:0] RESET_STATE = '0;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   taken;

  always_ff @(posedge clk) begin
    if (rst) state_q <= state_t'(RESET_STATE);
    else     state_q <= state_d;
  end

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      (funct3 == 3'b000): taken = zero;
      (funct3 == 3'b001): taken = ~zero;
      default:            taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          7'b0000011,
          7'b0100011: state_d = S_MEMADR;
          7'b0110011: state_d = S_EXECR;
          7'b0010011: state_d = S_EXECI;
          7'b1100011: state_d = S_BRANCH;
          7'b1101111: state_d = S_JAL;
          default: begin
            illegal = 1'b1;
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        instr_done = 1'b1;
        pc_write   = taken;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_HALT: illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase
    // Reset silences every output, including debug state.
    if (rst) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign state_o = rst ? '0 : state_q;

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Table-driven, scoreboard-checked bench for riscv_multicycle_control.
module tb_riscv_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       instr_done, illegal;
  logic [3:0] state_o;

  riscv_multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        mr;
    logic [19:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,
  //  result_src,src_a,src_b,alu_op,instr_done,illegal,state}
  function automatic logic [19:0] E(
    input logic [3:0] st,
    input logic mreq, input logic mwr, input logic adr,
    input logic irw, input logic pcw, input logic rgw,
    input logic [1:0] rs, input logic [1:0] sa,
    input logic [1:0] sb, input logic [1:0] aop,
    input logic dn, input logic ill);
    return {mreq, mwr, adr, irw, pcw, rgw, rs, sa, sb, aop, dn, ill, st};
  endfunction

  task automatic add(input string n, input logic r, input logic [6:0] op,
                     input logic [2:0] f3, input logic z, input logic mr,
                     input logic [19:0] x);
    vec_t v;
    v.name = n; v.rst = r; v.op = op; v.f3 = f3;
    v.z = z; v.mr = mr; v.exp = x;
    vecs.push_back(v);
  endtask

  initial begin
    logic [19:0] ZERO, FET1, FET0, DEC, DECI, MADR, MRD, MWB;
    logic [19:0] MWR0, MWR1, EXR, EXI, AWB, BRT, BRN, JALS, HLT;
    logic [19:0] got, want;

    ZERO = '0;
    FET1 = E(4'd0, 1,0,0,1,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 0,0);
    FET0 = E(4'd0, 1,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 0,0);
    DEC  = E(4'd1, 0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 0,0);
    DECI = E(4'd1, 0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 0,1);
    MADR = E(4'd2, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 0,0);
    MRD  = E(4'd3, 1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0);
    MWB  = E(4'd4, 0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 1,0);
    MWR0 = E(4'd5, 1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0);
    MWR1 = E(4'd5, 1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 1,0);
    EXR  = E(4'd6, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 0,0);
    EXI  = E(4'd7, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b11, 0,0);
    AWB  = E(4'd8, 0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 1,0);
    BRT  = E(4'd9, 0,0,0,0,1,0, 2'b00, 2'b10, 2'b00, 2'b01, 1,0);
    BRN  = E(4'd9, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b01, 1,0);
    JALS = E(4'd10,0,0,0,0,1,0, 2'b00, 2'b01, 2'b10, 2'b00, 0,0);
    HLT  = E(4'd11,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,1);

    add("rst0",     1, OP_R, 3'd0, 0, 1, ZERO);
    add("rst1",     1, OP_R, 3'd0, 0, 1, ZERO);
    add("add_f",    0, OP_R, 3'd0, 0, 1, FET1);
    add("add_d",    0, OP_R, 3'd0, 0, 0, DEC);
    add("add_x",    0, OP_R, 3'd0, 0, 0, EXR);
    add("add_wb",   0, OP_R, 3'd0, 0, 0, AWB);
    add("lw_f0",    0, OP_LW, 3'd2, 0, 0, FET0);
    add("lw_f",     0, OP_LW, 3'd2, 0, 1, FET1);
    add("lw_d",     0, OP_LW, 3'd2, 0, 1, DEC);
    add("lw_a",     0, OP_LW, 3'd2, 0, 1, MADR);
    add("lw_r0",    0, OP_LW, 3'd2, 0, 0, MRD);
    add("lw_r1",    0, OP_LW, 3'd2, 0, 0, MRD);
    add("lw_r2",    0, OP_LW, 3'd2, 0, 1, MRD);
    add("lw_wb",    0, OP_LW, 3'd2, 0, 1, MWB);
    add("sw_f",     0, OP_SW, 3'd2, 0, 1, FET1);
    add("sw_d",     0, OP_SW, 3'd2, 0, 1, DEC);
    add("sw_a",     0, OP_SW, 3'd2, 0, 1, MADR);
    add("sw_w",     0, OP_SW, 3'd2, 0, 1, MWR1);
    add("addi_f",   0, OP_I, 3'd0, 0, 1, FET1);
    add("addi_d",   0, OP_I, 3'd0, 0, 1, DEC);
    add("addi_x",   0, OP_I, 3'd0, 0, 1, EXI);
    add("addi_wb",  0, OP_I, 3'd0, 0, 1, AWB);
    add("beq_f",    0, OP_BR, 3'b000, 1, 1, FET1);
    add("beq_d",    0, OP_BR, 3'b000, 1, 1, DEC);
    add("beq_z1",   0, OP_BR, 3'b000, 1, 1, BRT);
    add("bne_f",    0, OP_BR, 3'b001, 1, 1, FET1);
    add("bne_d",    0, OP_BR, 3'b001, 1, 1, DEC);
    add("bne_z1",   0, OP_BR, 3'b001, 1, 1, BRN);
    add("bne2_f",   0, OP_BR, 3'b001, 0, 1, FET1);
    add("bne2_d",   0, OP_BR, 3'b001, 0, 1, DEC);
    add("bne_z0",   0, OP_BR, 3'b001, 0, 1, BRT);
    add("b100_f",   0, OP_BR, 3'b100, 1, 1, FET1);
    add("b100_d",   0, OP_BR, 3'b100, 1, 1, DEC);
    add("b100",     0, OP_BR, 3'b100, 1, 1, BRN);
    add("jal_f",    0, OP_JAL, 3'd0, 0, 1, FET1);
    add("jal_d",    0, OP_JAL, 3'd0, 0, 1, DEC);
    add("jal_j",    0, OP_JAL, 3'd0, 0, 1, JALS);
    add("jal_wb",   0, OP_JAL, 3'd0, 0, 1, AWB);
    add("ill_f",    0, OP_BAD, 3'd0, 0, 1, FET1);
    add("ill_d",    0, OP_BAD, 3'd0, 0, 1, DECI);
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    add("halt0",    0, OP_R, 3'd0, 0, 1, HLT);
    add("halt1",    0, OP_R, 3'd0, 1, 1, HLT);
    add("halt2",    0, OP_R, 3'd0, 0, 0, HLT);
    add("halt_rst", 1, OP_R, 3'd0, 0, 1, ZERO);
`else
    add("ill_nop",  0, OP_R, 3'd0, 0, 0, FET0);
    add("ill_nop1", 0, OP_R, 3'd0, 0, 1, FET1);
    add("ill_nop2", 0, OP_R, 3'd0, 0, 1, DEC);
    add("ill_nop3", 0, OP_R, 3'd0, 0, 1, EXR);
    add("ill_nop4", 0, OP_R, 3'd0, 0, 1, AWB);
    if (HLT == ZERO) add("unused", 0, OP_R, 3'd0, 0, 0, FET0);
`endif
    add("rsw_f",    0, OP_SW, 3'd2, 0, 1, FET1);
    add("rsw_d",    0, OP_SW, 3'd2, 0, 1, DEC);
    add("rsw_a",    0, OP_SW, 3'd2, 0, 1, MADR);
    add("rsw_w0",   0, OP_SW, 3'd2, 0, 0, MWR0);
    add("rsw_rst",  1, OP_SW, 3'd2, 0, 1, ZERO);
    add("rsw_post", 0, OP_SW, 3'd2, 0, 0, FET0);

    rst = 1'b1; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      opcode    = vecs[i].op;
      funct3    = vecs[i].f3;
      zero      = vecs[i].z;
      mem_ready = vecs[i].mr;
      exp_q.push_back(vecs[i].exp);
      #1;
      got  = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
              result_src, alu_src_a, alu_src_b, alu_op,
              instr_done, illegal, state_o};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL %s: got %05h expected %05h", vecs[i].name, got, want);
      end
      @(negedge clk);
    end

    rst = 1'b1; opcode = OP_R; funct3 = '0; zero = 1'b0; mem_ready = 1'b1;
    #1;
    checks++;
    if (state_o !== 4'd0) begin
      failures++;
      $display("FAIL d_rst_st: got %0d expected 0", state_o);
    end
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL d_rst_req: got %b expected 0", mem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0) begin
      failures++;
      $display("FAIL d_fet_st: got %0d expected 0", state_o);
    end
    checks++;
    if (ir_write !== 1'b1) begin
      failures++;
      $display("FAIL d_fet_irw: got %b expected 1", ir_write);
    end
    @(negedge clk);
    #1;
    checks++;
    if (state_o !== 4'd1) begin
      failures++;
      $display("FAIL d_dec_st: got %0d expected 1", state_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (alu_op !== 2'b10) begin
      failures++;
      $display("FAIL d_exr_op: got %b expected 10", alu_op);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
